// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types and constants for the 2-master AXI4 round-robin arbiter.
// Optional performance counters in the top are enabled by AXI_ARB_PERF_EN.
package ysyx_24100006_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic MST_IFU  = 1'b0;
  localparam logic MST_MEMU = 1'b1;

  // On a tie the master that was not served last wins.
  function automatic logic rr_tie_pick(input logic last);
    return ~last;
  endfunction

endpackage

// File: rtl/ysyx_24100006_rr_pick2.sv
// Two-requester round-robin pick: combinational grant index from request
// bits and the index of the master that completed most recently.
module ysyx_24100006_rr_pick2
  import ysyx_24100006_axi_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = MST_IFU;
    unique case (req_i)
      2'b01:   grant_o = MST_IFU;
      2'b10:   grant_o = MST_MEMU;
      2'b11:   grant_o = rr_tie_pick(last_i);
      default: grant_o = MST_IFU;  // no request: value is not used
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_axi_rr_arbiter.sv
// 2-master (M0 = IFU, M1 = MEMU) to 1-slave AXI4 arbiter with independent,
// burst-aware read and write grants. AXI_ARB_PERF_EN adds grant/stall counters.
module ysyx_24100006_axi_rr_arbiter
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
`ifdef AXI_ARB_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic            clk_i,
  input  logic            reset_i,
  // M0 read
  input  logic            m0_arvalid_i,
  output logic            m0_arready_o,
  input  logic [AW-1:0]   m0_araddr_i,
  input  logic [7:0]      m0_arlen_i,
  input  logic [2:0]      m0_arsize_i,
  output logic            m0_rvalid_o,
  input  logic            m0_rready_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic [1:0]      m0_rresp_o,
  output logic            m0_rlast_o,
  // M0 write
  input  logic            m0_awvalid_i,
  output logic            m0_awready_o,
  input  logic [AW-1:0]   m0_awaddr_i,
  input  logic [7:0]      m0_awlen_i,
  input  logic [2:0]      m0_awsize_i,
  input  logic            m0_wvalid_i,
  output logic            m0_wready_o,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_wstrb_i,
  input  logic            m0_wlast_i,
  output logic            m0_bvalid_o,
  input  logic            m0_bready_i,
  output logic [1:0]      m0_bresp_o,
  // M1 read
  input  logic            m1_arvalid_i,
  output logic            m1_arready_o,
  input  logic [AW-1:0]   m1_araddr_i,
  input  logic [7:0]      m1_arlen_i,
  input  logic [2:0]      m1_arsize_i,
  output logic            m1_rvalid_o,
  input  logic            m1_rready_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic [1:0]      m1_rresp_o,
  output logic            m1_rlast_o,
  // M1 write
  input  logic            m1_awvalid_i,
  output logic            m1_awready_o,
  input  logic [AW-1:0]   m1_awaddr_i,
  input  logic [7:0]      m1_awlen_i,
  input  logic [2:0]      m1_awsize_i,
  input  logic            m1_wvalid_i,
  output logic            m1_wready_o,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_wstrb_i,
  input  logic            m1_wlast_i,
  output logic            m1_bvalid_o,
  input  logic            m1_bready_i,
  output logic [1:0]      m1_bresp_o,
  // Slave port
  output logic            s_arvalid_o,
  input  logic            s_arready_i,
  output logic [AW-1:0]   s_araddr_o,
  output logic [7:0]      s_arlen_o,
  output logic [2:0]      s_arsize_o,
  input  logic            s_rvalid_i,
  output logic            s_rready_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic [1:0]      s_rresp_i,
  input  logic            s_rlast_i,
  output logic            s_awvalid_o,
  input  logic            s_awready_i,
  output logic [AW-1:0]   s_awaddr_o,
  output logic [7:0]      s_awlen_o,
  output logic [2:0]      s_awsize_o,
  output logic            s_wvalid_o,
  input  logic            s_wready_i,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_wstrb_o,
  output logic            s_wlast_o,
  input  logic            s_bvalid_i,
  output logic            s_bready_o,
  input  logic [1:0]      s_bresp_i
`ifdef AXI_ARB_PERF_EN
  , output logic [PERF_W-1:0] perf_rd_grant0_o,
  output logic [PERF_W-1:0] perf_rd_grant1_o,
  output logic [PERF_W-1:0] perf_wr_grant0_o,
  output logic [PERF_W-1:0] perf_wr_grant1_o,
  output logic [PERF_W-1:0] perf_rd_stall_o
`endif
);

  rd_state_e rd_state_q;
  wr_state_e wr_state_q;
  logic      rd_gnt_q, wr_gnt_q;
  logic      rr_last_r_q, rr_last_w_q;
  logic      aw_done_q, w_done_q;
  logic      rd_pick, wr_pick;
  logic      ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

  ysyx_24100006_rr_pick2 u_rd_pick (
    .req_i   ({m1_arvalid_i, m0_arvalid_i}),
    .last_i  (rr_last_r_q),
    .grant_o (rd_pick)
  );

  ysyx_24100006_rr_pick2 u_wr_pick (
    .req_i   ({m1_awvalid_i, m0_awvalid_i}),
    .last_i  (rr_last_w_q),
    .grant_o (wr_pick)
  );

  assign ar_hs     = s_arvalid_o & s_arready_i;
  assign r_last_hs = s_rvalid_i & s_rready_o & s_rlast_i;
  assign aw_hs     = s_awvalid_o & s_awready_i;
  assign w_last_hs = s_wvalid_o & s_wready_i & s_wlast_o;
  assign b_hs      = s_bvalid_i & s_bready_o;

  // Read channel mux/demux; everything is zero outside the owning state.
  always_comb begin
    s_arvalid_o  = 1'b0;
    s_araddr_o   = '0;
    s_arlen_o    = '0;
    s_arsize_o   = '0;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    s_rready_o   = 1'b0;
    m0_rvalid_o  = 1'b0;
    m0_rdata_o   = '0;
    m0_rresp_o   = '0;
    m0_rlast_o   = 1'b0;
    m1_rvalid_o  = 1'b0;
    m1_rdata_o   = '0;
    m1_rresp_o   = '0;
    m1_rlast_o   = 1'b0;
    unique case (rd_state_q)
      R_ADDR: begin
        if (rd_gnt_q == MST_MEMU) begin
          s_arvalid_o  = m1_arvalid_i;
          s_araddr_o   = m1_araddr_i;
          s_arlen_o    = m1_arlen_i;
          s_arsize_o   = m1_arsize_i;
          m1_arready_o = s_arready_i;
        end else begin
          s_arvalid_o  = m0_arvalid_i;
          s_araddr_o   = m0_araddr_i;
          s_arlen_o    = m0_arlen_i;
          s_arsize_o   = m0_arsize_i;
          m0_arready_o = s_arready_i;
        end
      end
      R_DATA: begin
        if (rd_gnt_q == MST_MEMU) begin
          s_rready_o  = m1_rready_i;
          m1_rvalid_o = s_rvalid_i;
          m1_rdata_o  = s_rdata_i;
          m1_rresp_o  = s_rresp_i;
          m1_rlast_o  = s_rlast_i;
        end else begin
          s_rready_o  = m0_rready_i;
          m0_rvalid_o = s_rvalid_i;
          m0_rdata_o  = s_rdata_i;
          m0_rresp_o  = s_rresp_i;
          m0_rlast_o  = s_rlast_i;
        end
      end
      default: ;
    endcase
  end

  // Write channel mux/demux; AW and W are each masked once their part is done.
  always_comb begin
    s_awvalid_o  = 1'b0;
    s_awaddr_o   = '0;
    s_awlen_o    = '0;
    s_awsize_o   = '0;
    s_wvalid_o   = 1'b0;
    s_wdata_o    = '0;
    s_wstrb_o    = '0;
    s_wlast_o    = 1'b0;
    m0_awready_o = 1'b0;
    m1_awready_o = 1'b0;
    m0_wready_o  = 1'b0;
    m1_wready_o  = 1'b0;
    s_bready_o   = 1'b0;
    m0_bvalid_o  = 1'b0;
    m0_bresp_o   = '0;
    m1_bvalid_o  = 1'b0;
    m1_bresp_o   = '0;
    unique case (wr_state_q)
      W_XFER: begin
        if (wr_gnt_q == MST_MEMU) begin
          s_awvalid_o  = m1_awvalid_i & ~aw_done_q;
          s_awaddr_o   = m1_awaddr_i;
          s_awlen_o    = m1_awlen_i;
          s_awsize_o   = m1_awsize_i;
          m1_awready_o = s_awready_i & ~aw_done_q;
          s_wvalid_o   = m1_wvalid_i & ~w_done_q;
          s_wdata_o    = m1_wdata_i;
          s_wstrb_o    = m1_wstrb_i;
          s_wlast_o    = m1_wlast_i;
          m1_wready_o  = s_wready_i & ~w_done_q;
        end else begin
          s_awvalid_o  = m0_awvalid_i & ~aw_done_q;
          s_awaddr_o   = m0_awaddr_i;
          s_awlen_o    = m0_awlen_i;
          s_awsize_o   = m0_awsize_i;
          m0_awready_o = s_awready_i & ~aw_done_q;
          s_wvalid_o   = m0_wvalid_i & ~w_done_q;
          s_wdata_o    = m0_wdata_i;
          s_wstrb_o    = m0_wstrb_i;
          s_wlast_o    = m0_wlast_i;
          m0_wready_o  = s_wready_i & ~w_done_q;
        end
      end
      W_RESP: begin
        if (wr_gnt_q == MST_MEMU) begin
          s_bready_o  = m1_bready_i;
          m1_bvalid_o = s_bvalid_i;
          m1_bresp_o  = s_bresp_i;
        end else begin
          s_bready_o  = m0_bready_i;
          m0_bvalid_o = s_bvalid_i;
          m0_bresp_o  = s_bresp_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q  <= R_IDLE;
      rd_gnt_q    <= MST_IFU;
      rr_last_r_q <= MST_IFU;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (m0_arvalid_i | m1_arvalid_i) begin
            rd_gnt_q   <= rd_pick;
            rd_state_q <= R_ADDR;
          end
        end
        R_ADDR: if (ar_hs) rd_state_q <= R_DATA;
        R_DATA: begin
          if (r_last_hs) begin
            rr_last_r_q <= rd_gnt_q;
            rd_state_q  <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state_q  <= W_IDLE;
      wr_gnt_q    <= MST_IFU;
      rr_last_w_q <= MST_IFU;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (m0_awvalid_i | m1_awvalid_i) begin
            wr_gnt_q   <= wr_pick;
            wr_state_q <= W_XFER;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
          end
        end
        W_XFER: begin
          if ((aw_done_q | aw_hs) && (w_done_q | w_last_hs)) begin
            wr_state_q <= W_RESP;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
          end else begin
            if (aw_hs)     aw_done_q <= 1'b1;
            if (w_last_hs) w_done_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            rr_last_w_q <= wr_gnt_q;
            wr_state_q  <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

`ifdef AXI_ARB_PERF_EN
  logic [PERF_W-1:0] perf_rd_grant0_q, perf_rd_grant1_q;
  logic [PERF_W-1:0] perf_wr_grant0_q, perf_wr_grant1_q;
  logic [PERF_W-1:0] perf_rd_stall_q;
  logic              rd_grant_ev, wr_grant_ev, rd_owner, rd_stall_ev;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  assign rd_grant_ev = (rd_state_q == R_IDLE) & (m0_arvalid_i | m1_arvalid_i);
  assign wr_grant_ev = (wr_state_q == W_IDLE) & (m0_awvalid_i | m1_awvalid_i);
  // In idle the master being picked this cycle counts as the owner.
  assign rd_owner    = (rd_state_q == R_IDLE) ? rd_pick : rd_gnt_q;
  assign rd_stall_ev = (m0_arvalid_i & (rd_owner != MST_IFU)) |
                       (m1_arvalid_i & (rd_owner != MST_MEMU));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_rd_grant0_q <= '0;
      perf_rd_grant1_q <= '0;
      perf_wr_grant0_q <= '0;
      perf_wr_grant1_q <= '0;
      perf_rd_stall_q  <= '0;
    end else begin
      if (rd_grant_ev && rd_pick == MST_IFU)  perf_rd_grant0_q <= sat_inc(perf_rd_grant0_q);
      if (rd_grant_ev && rd_pick == MST_MEMU) perf_rd_grant1_q <= sat_inc(perf_rd_grant1_q);
      if (wr_grant_ev && wr_pick == MST_IFU)  perf_wr_grant0_q <= sat_inc(perf_wr_grant0_q);
      if (wr_grant_ev && wr_pick == MST_MEMU) perf_wr_grant1_q <= sat_inc(perf_wr_grant1_q);
      if (rd_stall_ev)                        perf_rd_stall_q  <= sat_inc(perf_rd_stall_q);
    end
  end

  assign perf_rd_grant0_o = perf_rd_grant0_q;
  assign perf_rd_grant1_o = perf_rd_grant1_q;
  assign perf_wr_grant0_o = perf_wr_grant0_q;
  assign perf_wr_grant1_o = perf_wr_grant1_q;
  assign perf_rd_stall_o  = perf_rd_stall_q;
`endif

endmodule
